// File: rtl/m_mem_master_if.sv
// m_mem_master_if: M-stage operation and data-memory bus signals of the memory master
interface m_mem_master_if;
  logic        op_valid;
  logic        op_write;
  logic [1:0]  op_size;
  logic        op_signed;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] pc;
  logic        stall;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        misalign;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  modport master (
    input  op_valid, op_write, op_size, op_signed, addr, wdata, pc, mem_ack, mem_rdata,
    output stall, rdata, rdata_valid, misalign, mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
  modport slave (
    output op_valid, op_write, op_size, op_signed, addr, wdata, pc, mem_ack, mem_rdata,
    input  stall, rdata, rdata_valid, misalign, mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/m_mem_master.sv
// m_mem_master: turns one M-stage load/store into a req/ack data-memory transaction
module m_mem_master #(
  parameter int DM_WORDS = 4096
) (
  input  logic clk,
  input  logic reset,
  m_mem_master_if.master bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [32:0] LIMIT = 33'(DM_WORDS) * 33'd4;
  logic [1:0]  r_state;
  logic        r_write;
  logic [1:0]  r_size;
  logic        r_signed;
  logic [31:0] r_addr;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic [31:0] r_pc;
  logic [1:0]  r_off;
  logic [31:0] r_rdata;
  logic        w_word;
  logic        w_half;
  logic        w_bad;
  logic        w_idle;
  logic        w_accept;
  logic        w_req;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_lane;
  logic [31:0] w_load;
  logic [31:0] w_merged;
  assign w_word   = bus.op_size[1];
  assign w_half   = bus.op_size == 2'b01;
  assign w_bad    = (w_half & bus.addr[0]) | (w_word & |bus.addr[1:0]) | ({1'b0, bus.addr} >= LIMIT);
  // reset is folded in so combinational outputs drop the moment reset asserts
  assign w_idle   = reset & (r_state == IDLE);
  assign w_accept = w_idle & bus.op_valid & ~w_bad;
  assign w_req    = r_state == REQ;
  assign w_be     = ~bus.op_write | w_word ? 4'b1111 :
                    w_half ? 4'b0011 << {bus.addr[1], 1'b0} : 4'b0001 << bus.addr[1:0];
  assign w_wdata  = ~bus.op_write ? 32'd0 : w_word ? bus.wdata :
                    w_half ? {2{bus.wdata[15:0]}} : {4{bus.wdata[7:0]}};
  assign w_lane   = bus.mem_rdata >> {r_off, 3'b000};
  assign w_load   = r_size[1] ? bus.mem_rdata :
                    r_size[0] ? {{16{r_signed & w_lane[15]}}, w_lane[15:0]} :
                                {{24{r_signed & w_lane[7]}}, w_lane[7:0]};
  assign w_merged = r_wdata & {{8{r_be[3]}}, {8{r_be[2]}}, {8{r_be[1]}}, {8{r_be[0]}}};
  assign bus.stall       = w_accept | (reset & w_req);
  assign bus.misalign    = w_idle & bus.op_valid & w_bad;
  assign bus.mem_req     = reset & w_req;
  assign bus.mem_we      = reset & w_req & r_write;
  assign bus.mem_addr    = reset & w_req ? r_addr : 32'd0;
  assign bus.mem_be      = reset & w_req ? r_be : 4'd0;
  assign bus.mem_wdata   = reset & w_req ? r_wdata : 32'd0;
  assign bus.rdata_valid = reset & (r_state == DONE) & ~r_write;
  assign bus.rdata       = r_rdata;
  // transaction FSM: latch the access in IDLE, hold the bus in REQ until ack, present in DONE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_write  <= 1'b0;
      r_size   <= 2'd0;
      r_signed <= 1'b0;
      r_addr   <= 32'd0;
      r_be     <= 4'd0;
      r_wdata  <= 32'd0;
      r_pc     <= 32'd0;
      r_off    <= 2'd0;
      r_rdata  <= 32'd0;
    end else begin
      r_state <= w_accept ? REQ : w_req ? (bus.mem_ack ? DONE : REQ) : IDLE;
      if (w_accept) begin
        r_write  <= bus.op_write;
        r_size   <= bus.op_size;
        r_signed <= bus.op_signed;
        r_addr   <= {bus.addr[31:2], 2'b00};
        r_be     <= w_be;
        r_wdata  <= w_wdata;
        r_pc     <= bus.pc;
        r_off    <= bus.addr[1:0];
      end
      if (w_req && bus.mem_ack && !r_write) r_rdata <= w_load;
    end
  end
`ifndef SYNTHESIS
  // store log, emitted on the cycle a write is acknowledged
  always_ff @(posedge clk) begin
    if (reset && w_req && bus.mem_ack && r_write)
      $display("%d@%h: *%h <= %h", $time, r_pc, r_addr, w_merged);
  end
`endif
endmodule

// File: tb/tb_m_mem_master.sv
// tb_m_mem_master: directed and randomized load/store checks against an arithmetic reference model
module tb_m_mem_master;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int failures = 0;
  logic [31:0] hold = 32'd0;
  m_mem_master_if bus();
  m_mem_master #(.DM_WORDS(4096)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic access(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                        input int waits);
    logic bad;
    logic [31:0] e_be, e_wd, e_rd, lane;
    int o, st;
    o = int'(a % 4);
    bad = (sz == 2'd1 && a[0]) || (sz >= 2'd2 && o != 0) || (a >= 32'd16384);
    e_be = (!w || sz >= 2'd2) ? 32'd15 : (sz == 2'd1) ? 32'd3 << o : 32'd1 << o;
    e_wd = !w ? 32'd0 : (sz >= 2'd2) ? wd :
           (sz == 2'd1) ? (wd & 32'hFFFF) * 32'h00010001 : (wd & 32'hFF) * 32'h01010101;
    lane = rd >> (8 * o);
    e_rd = (sz >= 2'd2) ? rd :
           (sz == 2'd1) ? ((sg && lane[15]) ? (lane | 32'hFFFF0000) : (lane & 32'hFFFF)) :
                          ((sg && lane[7]) ? (lane | 32'hFFFFFF00) : (lane & 32'hFF));
    @(posedge clk); #1;
    bus.op_valid = 1'b1; bus.op_write = w; bus.op_size = sz; bus.op_signed = sg;
    bus.addr = a; bus.wdata = wd; bus.pc = $urandom; bus.mem_ack = 1'b0;
    @(negedge clk);
    chk("misalign", {31'd0, bus.misalign}, {31'd0, bad});
    chk("req_idle", {31'd0, bus.mem_req}, 32'd0);
    if (bad) begin
      chk("stall_rej", {31'd0, bus.stall}, 32'd0);
      @(posedge clk); #1 bus.op_valid = 1'b0;
      @(negedge clk);
      chk("req_after_rej", {31'd0, bus.mem_req}, 32'd0);
      chk("misalign_drop", {31'd0, bus.misalign}, 32'd0);
      return;
    end
    st = int'(bus.stall);
    for (int i = 0; i <= waits; i++) begin
      @(posedge clk); #1;
      bus.mem_ack = (i == waits);
      bus.mem_rdata = (i == waits) ? rd : $urandom;
      @(negedge clk);
      st += int'(bus.stall);
      chk("mem_req", {31'd0, bus.mem_req}, 32'd1);
      chk("mem_we", {31'd0, bus.mem_we}, {31'd0, w});
      chk("mem_addr", bus.mem_addr, a & 32'hFFFFFFFC);
      chk("mem_be", {28'd0, bus.mem_be}, e_be);
      chk("mem_wdata", bus.mem_wdata, e_wd);
    end
    @(posedge clk); #1;
    bus.mem_ack = 1'b0; bus.op_valid = 1'b0; bus.mem_rdata = $urandom;
    @(negedge clk);
    st += int'(bus.stall);
    chk("stall_cycles", st, waits + 2);
    chk("req_done", {31'd0, bus.mem_req}, 32'd0);
    chk("rdata_valid", {31'd0, bus.rdata_valid}, {31'd0, !w});
    if (!w) hold = e_rd;
    chk("rdata", bus.rdata, hold);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rvalid_pulse", {31'd0, bus.rdata_valid}, 32'd0);
    chk("rdata_hold", bus.rdata, hold);
  endtask

  initial begin
    bus.op_valid = 1'b1; bus.op_write = 1'b1; bus.op_size = 2'd2; bus.op_signed = 1'b0;
    bus.addr = 32'h10; bus.wdata = 32'h1; bus.pc = 32'h0;
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hFFFFFFFF;
    repeat (2) @(negedge clk);
    chk("rst_stall", {31'd0, bus.stall}, 32'd0);
    chk("rst_req", {31'd0, bus.mem_req}, 32'd0);
    chk("rst_misalign", {31'd0, bus.misalign}, 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);
    chk("rst_addr", bus.mem_addr, 32'd0);
    bus.op_valid = 1'b0; bus.mem_ack = 1'b0;
    #1 reset = 1'b1;
    @(negedge clk);
    chk("idle_req", {31'd0, bus.mem_req}, 32'd0);
    chk("idle_stall", {31'd0, bus.stall}, 32'd0);
    access(1'b1, 2'd2, 1'b0, 32'h10, 32'h12345678, 32'h0, 0);
    access(1'b1, 2'd0, 1'b0, 32'h13, 32'h000000AB, 32'h0, 3);
    access(1'b0, 2'd0, 1'b1, 32'h21, 32'h0, 32'h0000F000, 1);
    access(1'b0, 2'd0, 1'b0, 32'h21, 32'h0, 32'h0000F000, 0);
    access(1'b0, 2'd1, 1'b1, 32'h22, 32'h0, 32'h80010000, 2);
    access(1'b0, 2'd1, 1'b0, 32'h22, 32'h0, 32'h80010000, 0);
    access(1'b0, 2'd2, 1'b0, 32'h6, 32'h0, 32'h0, 0);
    access(1'b1, 2'd1, 1'b0, 32'h4001, 32'hBEEF, 32'h0, 0);
    access(1'b1, 2'd2, 1'b0, 32'h4000, 32'h1, 32'h0, 0);
    access(1'b0, 2'd3, 1'b0, 32'h3FFC, 32'h0, 32'hCAFEF00D, 1);
    // reset in the middle of a request
    @(posedge clk); #1;
    bus.op_valid = 1'b1; bus.op_write = 1'b1; bus.op_size = 2'd2; bus.addr = 32'h40;
    bus.wdata = 32'hDEADBEEF; bus.mem_ack = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("pre_rst_req", {31'd0, bus.mem_req}, 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("rst_req_drop", {31'd0, bus.mem_req}, 32'd0);
    chk("rst_stall_drop", {31'd0, bus.stall}, 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_rdata_clr", bus.rdata, 32'd0);
    bus.op_valid = 1'b0;
    hold = 32'd0;
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chk("post_rst_req", {31'd0, bus.mem_req}, 32'd0);
    chk("post_rst_stall", {31'd0, bus.stall}, 32'd0);
    access(1'b1, 2'd2, 1'b0, 32'h40, 32'h0BADF00D, 32'h0, 0);
    for (int n = 0; n < 60; n++) begin
      logic [1:0] sz;
      logic [31:0] a;
      sz = 2'($urandom_range(0, 3));
      a = $urandom_range(0, 16383);
      if ($urandom_range(0, 3) != 0) a = (sz == 2'd0) ? a : (sz == 2'd1) ? (a & 32'hFFFE) : (a & 32'hFFFC);
      if ($urandom_range(0, 9) == 0) a = a + 32'd16384;
      access(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, $urandom,
             $urandom_range(0, 3));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
